spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: TURNAROUND, default 1, idle MOSI cycles between the last command bit and the first MISO sample on read-data frames, legal range 0..7.
REQ-002 clk  input  1  single clock; all logic on posedge clk; SPI bit rate equals clk rate.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a frame; sampled only in IDLE.
REQ-005 cmd  input  2  frame command: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-006 din  input  8  address/data byte for the frame.
REQ-007 MISO  input  1  serial data from the slave.
REQ-008 SS_n  output  1  slave select, active-low, registered.
REQ-009 MOSI  output  1  serial data to the slave, registered, MSB first.
REQ-010 busy  output  1  high from the cycle after start is accepted until the cycle after done.
REQ-011 done  output  1  one-cycle pulse at frame end.
REQ-012 rd_data  output  8  byte received on the last read-data frame; holds until the next read-data frame completes.
REQ-013 rd_valid  output  1  one-cycle pulse with rd_data update; read-data frames only.

Function
REQ-014 States: IDLE, START, SHIFT, WAIT, RECV, END; 4-bit bit counter; 10-bit TX shift register; 8-bit RX shift register.
REQ-015 IDLE: SS_n=1, MOSI=0, busy=0; when start=1 at edge E0, latch {cmd,din} into TX register, go to START.
REQ-016 START (one cycle after E0): SS_n=0, MOSI=0, busy=1; next edge E1 goes to SHIFT.
REQ-017 SHIFT: 10 cycles; MOSI carries cmd[1], cmd[0], din[7]..din[0], one bit per cycle, bit k valid in the cycle after edge E(1+k).
REQ-018 After the 10th SHIFT cycle (edge E11): cmd!=11 goes to END; cmd==11 goes to WAIT if TURNAROUND>0, otherwise directly to RECV.
REQ-019 WAIT: TURNAROUND cycles, SS_n=0, MOSI=0.
REQ-020 RECV: 8 cycles, SS_n=0, MOSI=0; MISO is sampled at the closing edge of each RECV cycle, shifted in MSB first.
REQ-021 At the closing edge of the 8th RECV cycle: rd_data <= assembled byte, rd_valid=1 for one cycle, go to END.
REQ-022 END: one cycle, SS_n=1, done=1, busy=1; next edge returns to IDLE, where busy=0.
REQ-023 SS_n shall stay low continuously from START through the last SHIFT/WAIT/RECV cycle, with no glitches; it returns high for at least one cycle (END) between frames.
REQ-024 start asserted while busy shall be ignored; no queuing.
REQ-025 cmd/din changes after E0 shall not affect the frame in progress.
REQ-026 Back-to-back: start held high during END shall be accepted at the first IDLE edge, giving a 2-cycle SS_n-high gap (END + IDLE).
REQ-027 Write frame (cmd!=11) length: SS_n low 11 cycles; done 12 cycles after E0.
REQ-028 Read-data frame length: SS_n low 19+TURNAROUND cycles.

Reset
REQ-029 rst_n=0 at any edge, including mid-frame, forces: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, counters 0.
REQ-030 An aborted frame shall produce no done or rd_valid pulse; rd_data shall not update.

Verification
REQ-031 start, cmd=00, din=8'hA5 -> MOSI bits 0,0,1,0,1,0,0,1,0,1; SS_n low 11 cycles; done one cycle; rd_valid stays 0.
REQ-032 start, cmd=11, din=8'h3C, TURNAROUND=1, slave model drives 8'hC3 on MISO during RECV -> rd_data=8'hC3, rd_valid and done in the same cycle; SS_n low 20 cycles.
REQ-033 start pulsed again at SHIFT cycle 4 with cmd=01 -> ignored; the first frame completes unchanged; only one done pulse.
REQ-034 rst_n=0 for one cycle during RECV cycle 3 -> SS_n=1 next cycle; no done or rd_valid; rd_data retains 8'h00.
REQ-035 start held high continuously, cmd=01, din=8'hFF -> consecutive frames with exactly 2 SS_n-high cycles between them; each frame sends 0,1,1,1,1,1,1,1,1,1.
REQ-036 TURNAROUND=0, cmd=11, MISO=8'h81 -> RECV immediately follows SHIFT; rd_data=8'h81; SS_n low 19 cycles.

Source files
------------

// File: rtl/spi_master_if.sv
// Host-side bus of the SPI master: frame request, serial pins and status.
// The DUT connects through "master"; the driving environment uses "slave".
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       MISO;
  logic       SS_n;
  logic       MOSI;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    input  start, cmd, din, MISO,
    output SS_n, MOSI, busy, done, rd_data, rd_valid
  );

  modport slave (
    output start, cmd, din, MISO,
    input  SS_n, MOSI, busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/spi_master.sv
// SPI frame master: 2-bit command + 8-bit byte out on MOSI, optional
// turnaround gap and 8-bit MISO capture on read-data frames.
module spi_master #(
  parameter int TURNAROUND = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  localparam logic [3:0] LAST_TX   = 4'd9;
  localparam logic [3:0] LAST_RX   = 4'd7;
  localparam logic [3:0] LAST_WAIT = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  logic [2:0] r_state, w_state;
  logic [3:0] r_cnt,   w_cnt;
  logic [9:0] r_tx,    w_tx;
  logic [7:0] r_rx,    w_rx;
  logic       r_is_rd, w_is_rd;
  logic       r_ss_n,  w_ss_n;
  logic       r_mosi,  w_mosi;
  logic       r_busy,  w_busy;
  logic       r_done,  w_done;
  logic       r_rd_valid, w_rd_valid;
  logic [7:0] r_rd_data,  w_rd_data;

  // Every output is computed one cycle ahead so the pins come straight off flops.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_tx       = r_tx;
    w_rx       = r_rx;
    w_is_rd    = r_is_rd;
    w_ss_n     = r_ss_n;
    w_mosi     = 1'b0;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_rd_valid = 1'b0;
    w_rd_data  = r_rd_data;

    case (r_state)
      S_IDLE: begin
        w_ss_n = 1'b1;
        w_busy = 1'b0;
        w_cnt  = 4'd0;
        w_rx   = 8'h00;
        if (bus.start) begin
          w_state = S_START;
          w_tx    = {bus.cmd, bus.din};
          w_is_rd = (bus.cmd == 2'b11);
          w_ss_n  = 1'b0;
          w_busy  = 1'b1;
        end
      end

      S_START: begin
        w_state = S_SHIFT;
        w_mosi  = r_tx[9];
        w_tx    = {r_tx[8:0], 1'b0};
        w_cnt   = 4'd0;
      end

      S_SHIFT: begin
        if (r_cnt == LAST_TX) begin
          w_cnt = 4'd0;
          if (!r_is_rd) begin
            w_state = S_END;
            w_ss_n  = 1'b1;
            w_done  = 1'b1;
          end else if (TURNAROUND > 0) begin
            w_state = S_WAIT;
          end else begin
            w_state = S_RECV;
          end
        end else begin
          w_mosi = r_tx[9];
          w_tx   = {r_tx[8:0], 1'b0};
          w_cnt  = r_cnt + 4'd1;
        end
      end

      S_WAIT: begin
        if (r_cnt == LAST_WAIT) begin
          w_state = S_RECV;
          w_cnt   = 4'd0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end

      S_RECV: begin
        w_rx = {r_rx[6:0], bus.MISO};
        if (r_cnt == LAST_RX) begin
          w_state    = S_END;
          w_cnt      = 4'd0;
          w_rd_data  = w_rx;
          w_rd_valid = 1'b1;
          w_done     = 1'b1;
          w_ss_n     = 1'b1;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end

      S_END: begin
        // busy stays high through END and drops on the return to IDLE.
        w_state = S_IDLE;
        w_ss_n  = 1'b1;
        w_busy  = 1'b0;
      end

      default: begin
        w_state = S_IDLE;
        w_ss_n  = 1'b1;
        w_busy  = 1'b0;
        w_cnt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_tx       <= 10'd0;
      r_rx       <= 8'h00;
      r_is_rd    <= 1'b0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_tx       <= w_tx;
      r_rx       <= w_rx;
      r_is_rd    <= w_is_rd;
      r_ss_n     <= w_ss_n;
      r_mosi     <= w_mosi;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_rd_valid <= w_rd_valid;
      r_rd_data  <= w_rd_data;
    end
  end

  assign bus.SS_n     = r_ss_n;
  assign bus.MOSI     = r_mosi;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (TURNAROUND=1 and 0) share
// stimulus; a negedge monitor measures each frame and checks it on done.
module tb_spi_master;

  typedef struct {
    int         len;
    logic [9:0] bits;
    bit         is_rd;
    logic [7:0] rd;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic       miso = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] miso_byte = 8'h00;

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_master_if b1 ();
  spi_master_if b0 ();

  assign b1.start = start & ~sel;
  assign b0.start = start & sel;
  assign b1.cmd = cmd;
  assign b0.cmd = cmd;
  assign b1.din = din;
  assign b0.din = din;
  assign b1.MISO = miso;
  assign b0.MISO = miso;

  spi_master #(.TURNAROUND(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  spi_master #(.TURNAROUND(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  logic       m_ss_n, m_mosi, m_busy, m_done, m_rd_valid;
  logic [7:0] m_rd_data;
  assign m_ss_n     = sel ? b0.SS_n     : b1.SS_n;
  assign m_mosi     = sel ? b0.MOSI     : b1.MOSI;
  assign m_busy     = sel ? b0.busy     : b1.busy;
  assign m_done     = sel ? b0.done     : b1.done;
  assign m_rd_valid = sel ? b0.rd_valid : b1.rd_valid;
  assign m_rd_data  = sel ? b0.rd_data  : b1.rd_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor + slave model: frame measurements and MISO driving.
  int low_cnt = 0, high_cnt = 0, last_len = 0, frame_gap = 0;
  logic [9:0] cap = 10'd0;
  bit extra_nz = 1'b0;

  always @(negedge clk) begin
    int ta;
    int idx;
    exp_t e;
    ta = sel ? 0 : 1;
    miso = 1'b0;
    if (!m_ss_n) begin
      idx = low_cnt;
      if (idx == 0) begin
        frame_gap = high_cnt;
        cap = 10'd0;
        extra_nz = 1'b0;
      end
      if (idx >= 1 && idx <= 10) cap = {cap[8:0], m_mosi};
      else if (m_mosi) extra_nz = 1'b1;
      if (idx >= 11 + ta && idx < 19 + ta) miso = miso_byte[7 - (idx - 11 - ta)];
      low_cnt++;
      high_cnt = 0;
    end else begin
      if (low_cnt != 0) last_len = low_cnt;
      low_cnt = 0;
      high_cnt++;
    end

    if (m_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no frame pending");
      end else begin
        e = exp_q.pop_front();
        check("ss_low_len", last_len, e.len);
        check("mosi_bits", {22'd0, cap}, {22'd0, e.bits});
        check("mosi_zero_outside_shift", {31'd0, extra_nz}, 32'd0);
        check("rd_valid_with_done", {31'd0, m_rd_valid}, {31'd0, e.is_rd});
        if (e.is_rd) check("rd_data", {24'd0, m_rd_data}, {24'd0, e.rd});
        if (e.gap != 0) check("ss_high_gap", frame_gap, e.gap);
      end
    end else if (m_rd_valid) begin
      check("rd_valid_without_done", {31'd0, m_rd_valid}, 32'd0);
    end
  end

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (n_done < target) check("done_timeout", n_done, target);
  endtask

  task automatic push(input int len, input logic [9:0] bits, input logic [7:0] rd, input int gap);
    exp_t e;
    e.len = len; e.bits = bits; e.is_rd = (bits[9:8] == 2'b11); e.rd = rd; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // One frame: start pulsed for one cycle, cmd/din scrambled right after acceptance.
  task automatic frame(input logic [1:0] c, input logic [7:0] d, input int len,
                       input logic [9:0] bits, input logic [7:0] rd);
    int target;
    target = n_done + 1;
    push(len, bits, rd, 0);
    miso_byte = rd;
    @(negedge clk);
    start = 1'b1; cmd = c; din = d;
    @(negedge clk);
    start = 1'b0; cmd = ~c; din = ~d;
    wait_done(target);
  endtask

  initial begin
    int saved;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ss_n", {31'd0, m_ss_n}, 32'd1);
    check("reset_mosi", {31'd0, m_mosi}, 32'd0);
    check("reset_busy", {31'd0, m_busy}, 32'd0);
    check("reset_done", {31'd0, m_done}, 32'd0);
    check("reset_rd_valid", {31'd0, m_rd_valid}, 32'd0);
    check("reset_rd_data", {24'd0, m_rd_data}, 32'd0);

    // Write-address A5: 0,0,1,0,1,0,0,1,0,1
    frame(2'b00, 8'hA5, 11, 10'b00_1010_0101, 8'h00);
    repeat (3) @(negedge clk);

    // Abort a read-data frame during RECV cycle 3 (cycle after E14).
    saved = n_done;
    miso_byte = 8'hFF;
    @(negedge clk);
    start = 1'b1; cmd = 2'b11; din = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_busy_before", {31'd0, m_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ss_n", {31'd0, m_ss_n}, 32'd1);
    check("abort_busy", {31'd0, m_busy}, 32'd0);
    check("abort_done", {31'd0, m_done}, 32'd0);
    check("abort_rd_valid", {31'd0, m_rd_valid}, 32'd0);
    check("abort_rd_data", {24'd0, m_rd_data}, 32'd0);
    repeat (25) @(negedge clk);
    check("abort_no_done", n_done, saved);
    check("abort_rd_data_hold", {24'd0, m_rd_data}, 32'd0);

    // Read-data 3C with TURNAROUND=1, slave returns C3.
    frame(2'b11, 8'h3C, 20, 10'b11_0011_1100, 8'hC3);
    repeat (3) @(negedge clk);
    check("rd_data_hold", {24'd0, m_rd_data}, 32'hC3);

    // Write-address 5A; a second start during SHIFT cycle 4 must be ignored.
    saved = n_done;
    push(11, 10'b00_0101_1010, 8'h00, 0);
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; din = 8'h5A;
    @(negedge clk);
    start = 1'b0; cmd = 2'b10; din = 8'h00;
    repeat (4) @(negedge clk);
    start = 1'b1; cmd = 2'b01; din = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(saved + 1);
    repeat (30) @(negedge clk);
    check("ignored_start_one_done", n_done, saved + 1);

    // start held high: back-to-back write-data FF frames, 2-cycle SS_n gap.
    saved = n_done;
    push(11, 10'b01_1111_1111, 8'h00, 0);
    push(11, 10'b01_1111_1111, 8'h00, 2);
    push(11, 10'b01_1111_1111, 8'h00, 2);
    @(negedge clk);
    start = 1'b1; cmd = 2'b01; din = 8'hFF;
    wait_done(saved + 2);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(saved + 3);
    repeat (20) @(negedge clk);
    check("b2b_frame_count", n_done, saved + 3);

    // TURNAROUND=0 instance: read-data 96, slave returns 81.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    frame(2'b11, 8'h96, 19, 10'b11_1001_0110, 8'h81);
    repeat (3) @(negedge clk);
    check("ta0_busy_idle", {31'd0, m_busy}, 32'd0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
